// File: rtl/multi_frequency_analyzer.sv
// rtl/multi_frequency_analyzer.sv - half-period tone analyser with per-bin accumulators
// Optional input glitch filter: define MFA_GLITCH_FILTER_EN.
module multi_frequency_analyzer #(
  parameter int N_BINS       = 2,
  parameter int PERIOD_WIDTH = 16,
  parameter int ACC_WIDTH    = 32,
  parameter int HIT_WIDTH    = 16,
  parameter int FILTER_DEPTH = 4,
  localparam int BIN_W       = (N_BINS > 1) ? $clog2(N_BINS) : 1
) (
  input  logic                           clock,
  input  logic                           clear,
  input  logic                           enable,
  input  logic                           sample_data,
  input  logic                           acc_clear,
  input  logic [N_BINS*PERIOD_WIDTH-1:0] bin_low,
  input  logic [N_BINS*PERIOD_WIDTH-1:0] bin_high,
  output logic [N_BINS*ACC_WIDTH-1:0]    bin_ticks,
  output logic [N_BINS*HIT_WIDTH-1:0]    bin_hits,
  output logic [HIT_WIDTH-1:0]           miss_count,
  output logic                           result_valid,
  output logic                           result_hit,
  output logic [BIN_W-1:0]               result_bin,
  output logic [PERIOD_WIDTH-1:0]        result_interval
);

  localparam int SUM_W = ((ACC_WIDTH > PERIOD_WIDTH) ? ACC_WIDTH : PERIOD_WIDTH) + 1;
  localparam logic [PERIOD_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [ACC_WIDTH-1:0]    ACC_MAX = '1;
  localparam logic [HIT_WIDTH-1:0]    HIT_MAX = '1;

  if (N_BINS < 1 || N_BINS > 16 || FILTER_DEPTH < 1) begin : g_bad_params
    $error("multi_frequency_analyzer: N_BINS must be 1..16 and FILTER_DEPTH >= 1");
  end

  typedef enum logic {IDLE, MEASURE} state_t;

  logic sync1_q, sync2_q, s_q, s_prev_q, edge_det;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      s_prev_q <= 1'b0;
    end else begin
      sync1_q  <= sample_data;
      sync2_q  <= sync1_q;
      s_prev_q <= s_q;
    end
  end

`ifdef MFA_GLITCH_FILTER_EN
  // s_q only follows once the last FILTER_DEPTH synchronised samples all agree
  logic [FILTER_DEPTH-1:0] hist_q;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      hist_q <= '0;
      s_q    <= 1'b0;
    end else begin
      hist_q <= (hist_q << 1) | FILTER_DEPTH'(sync2_q);
      if (&hist_q) begin
        s_q <= 1'b1;
      end else if (~|hist_q) begin
        s_q <= 1'b0;
      end
    end
  end
`else
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      s_q <= 1'b0;
    end else begin
      s_q <= sync2_q;
    end
  end
`endif

  assign edge_det = s_q ^ s_prev_q;

  state_t                  state_q, state_d;
  logic [PERIOD_WIDTH-1:0] period_cnt_q, period_cnt_d;
  logic                    meas_done, timeout;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q      <= IDLE;
      period_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      period_cnt_q <= period_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    period_cnt_d = period_cnt_q;
    meas_done    = 1'b0;
    timeout      = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable && edge_det) begin
          period_cnt_d = PERIOD_WIDTH'(1);
          state_d      = MEASURE;
        end
      end
      MEASURE: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (edge_det) begin
          meas_done    = 1'b1;
          period_cnt_d = PERIOD_WIDTH'(1);
        end else if (period_cnt_q == CNT_MAX) begin
          timeout = 1'b1;
          state_d = IDLE;
        end else begin
          period_cnt_d = period_cnt_q + PERIOD_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Lowest-index window containing the interval wins; sel is one-hot or zero
  logic             match_hit;
  logic [BIN_W-1:0] match_bin;
  logic [N_BINS-1:0] sel;

  always_comb begin
    match_hit = 1'b0;
    match_bin = '0;
    sel       = '0;
    for (int i = 0; i < N_BINS; i++) begin
      if (!match_hit &&
          bin_low[i*PERIOD_WIDTH +: PERIOD_WIDTH] <= period_cnt_q &&
          period_cnt_q <= bin_high[i*PERIOD_WIDTH +: PERIOD_WIDTH]) begin
        match_hit = 1'b1;
        match_bin = BIN_W'(i);
        sel[i]    = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < N_BINS; g++) begin : g_bin
    logic [ACC_WIDTH-1:0] ticks_q;
    logic [HIT_WIDTH-1:0] hits_q;
    logic [SUM_W-1:0]     sum;

    assign sum = SUM_W'(ticks_q) + SUM_W'(period_cnt_q);

    always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
        ticks_q <= '0;
        hits_q  <= '0;
      end else if (acc_clear) begin
        ticks_q <= '0;
        hits_q  <= '0;
      end else if (meas_done && sel[g]) begin
        ticks_q <= (sum > SUM_W'(ACC_MAX)) ? ACC_MAX : sum[ACC_WIDTH-1:0];
        if (hits_q != HIT_MAX) begin
          hits_q <= hits_q + HIT_WIDTH'(1);
        end
      end
    end

    assign bin_ticks[g*ACC_WIDTH +: ACC_WIDTH] = ticks_q;
    assign bin_hits[g*HIT_WIDTH +: HIT_WIDTH]  = hits_q;
  end

  logic [HIT_WIDTH-1:0]    miss_q;
  logic                    result_valid_q, result_hit_q;
  logic [BIN_W-1:0]        result_bin_q;
  logic [PERIOD_WIDTH-1:0] result_interval_q;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      miss_q            <= '0;
      result_valid_q    <= 1'b0;
      result_hit_q      <= 1'b0;
      result_bin_q      <= '0;
      result_interval_q <= '0;
    end else begin
      result_valid_q <= meas_done | timeout;
      if (meas_done) begin
        result_hit_q      <= match_hit;
        result_bin_q      <= match_bin;
        result_interval_q <= period_cnt_q;
      end else if (timeout) begin
        result_hit_q      <= 1'b0;
        result_bin_q      <= '0;
        result_interval_q <= CNT_MAX;
      end
      if (acc_clear) begin
        miss_q <= '0;
      end else if (((meas_done && !match_hit) || timeout) && miss_q != HIT_MAX) begin
        miss_q <= miss_q + HIT_WIDTH'(1);
      end
    end
  end

  assign miss_count      = miss_q;
  assign result_valid    = result_valid_q;
  assign result_hit      = result_hit_q;
  assign result_bin      = result_bin_q;
  assign result_interval = result_interval_q;

endmodule

// File: tb/tb_multi_frequency_analyzer.sv
// tb/tb_multi_frequency_analyzer.sv - directed self-checking bench for multi_frequency_analyzer
// A second 12-bit instance covers accumulator saturation and timeout within a short run.
module tb_multi_frequency_analyzer;

`ifdef MFA_GLITCH_FILTER_EN
  localparam int LAT = 3 + 4;
`else
  localparam int LAT = 3;
`endif
  localparam int SETTLE = LAT + 6;

  logic        clock = 1'b0;
  logic        clear, enable, sample_data, acc_clear;
  logic [31:0] bin_low, bin_high;
  logic [23:0] bin_low_s, bin_high_s;
  logic [63:0] bin_ticks;
  logic [31:0] bin_hits;
  logic [15:0] miss_count;
  logic        result_valid, result_hit;
  logic [0:0]  result_bin;
  logic [15:0] result_interval;
  logic [23:0] ticks_s;
  logic [31:0] hits_s;
  logic [15:0] miss_s;
  logic        valid_s, hit_s;
  logic [0:0]  bin_s;
  logic [11:0] interval_s;

  int checks = 0;
  int errors = 0;
  int q_int[$];
  int q_hit[$];
  int q_bin[$];
  int qs_int[$];
  int qs_hit[$];

  always #5 clock = ~clock;

  assign bin_low_s  = {bin_low[27:16], bin_low[11:0]};
  assign bin_high_s = {bin_high[27:16], bin_high[11:0]};

  multi_frequency_analyzer dut (
    .clock(clock), .clear(clear), .enable(enable), .sample_data(sample_data),
    .acc_clear(acc_clear), .bin_low(bin_low), .bin_high(bin_high),
    .bin_ticks(bin_ticks), .bin_hits(bin_hits), .miss_count(miss_count),
    .result_valid(result_valid), .result_hit(result_hit), .result_bin(result_bin),
    .result_interval(result_interval)
  );

  multi_frequency_analyzer #(.PERIOD_WIDTH(12), .ACC_WIDTH(12)) dut_s (
    .clock(clock), .clear(clear), .enable(enable), .sample_data(sample_data),
    .acc_clear(acc_clear), .bin_low(bin_low_s), .bin_high(bin_high_s),
    .bin_ticks(ticks_s), .bin_hits(hits_s), .miss_count(miss_s),
    .result_valid(valid_s), .result_hit(hit_s), .result_bin(bin_s),
    .result_interval(interval_s)
  );

  always @(negedge clock) begin
    if (result_valid === 1'b1) begin
      q_int.push_back(int'(result_interval));
      q_hit.push_back(int'(result_hit));
      q_bin.push_back(int'(result_bin));
    end
    if (valid_s === 1'b1) begin
      qs_int.push_back(int'(interval_s));
      qs_hit.push_back(int'(hit_s));
    end
  end

  task automatic settle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic toggle();
    sample_data = ~sample_data;
  endtask

  task automatic square(input int half, input int edges);
    for (int i = 0; i < edges; i++) begin
      toggle();
      if (i < edges - 1) settle(half);
    end
  endtask

  task automatic rearm();
    @(negedge clock);
    enable = 1'b0;
    settle(2);
    enable = 1'b1;
    @(negedge clock);
  endtask

  task automatic pulse_acc_clear();
    acc_clear = 1'b1;
    @(negedge clock);
    acc_clear = 1'b0;
    @(negedge clock);
  endtask

  task automatic flush_q();
    q_int.delete();
    q_hit.delete();
    q_bin.delete();
  endtask

  task automatic test_reset();
    clear = 1'b0; enable = 1'b0; sample_data = 1'b0; acc_clear = 1'b0;
    bin_low  = {16'd2045, 16'd2500};
    bin_high = {16'd2499, 16'd3055};
    settle(3);
    checks++; if (bin_ticks !== 64'd0) begin errors++; $display("FAIL reset_ticks got %0h want 0", bin_ticks); end
    checks++; if (bin_hits !== 32'd0) begin errors++; $display("FAIL reset_hits got %0h want 0", bin_hits); end
    checks++; if (miss_count !== 16'd0) begin errors++; $display("FAIL reset_miss got %0d want 0", miss_count); end
    checks++; if (result_valid !== 1'b0 || result_interval !== 16'd0) begin
      errors++; $display("FAIL reset_result got valid %0b interval %0d want 0 0", result_valid, result_interval);
    end
    clear = 1'b1;
    enable = 1'b1;
    settle(2);
  endtask

  task automatic test_tone_bin0();
    rearm(); pulse_acc_clear(); flush_q();
    square(2777, 5); settle(SETTLE);
    checks++; if (q_int.size() != 4) begin errors++; $display("FAIL tone0_count got %0d want 4", q_int.size()); end
    for (int i = 0; i < q_int.size(); i++) begin
      checks++; if (q_int[i] != 2777 || q_hit[i] != 1 || q_bin[i] != 0) begin
        errors++; $display("FAIL tone0_result[%0d] got int %0d hit %0d bin %0d want 2777 1 0", i, q_int[i], q_hit[i], q_bin[i]);
      end
    end
    checks++; if (bin_ticks[31:0] !== 32'd11108) begin errors++; $display("FAIL tone0_ticks got %0d want 11108", bin_ticks[31:0]); end
    checks++; if (bin_hits[15:0] !== 16'd4) begin errors++; $display("FAIL tone0_hits got %0d want 4", bin_hits[15:0]); end
    checks++; if (miss_count !== 16'd0 || bin_ticks[63:32] !== 32'd0) begin
      errors++; $display("FAIL tone0_other got miss %0d ticks1 %0d want 0 0", miss_count, bin_ticks[63:32]);
    end
  endtask

  task automatic test_bin1_and_overlap();
    rearm(); pulse_acc_clear(); flush_q();
    square(2272, 3); settle(SETTLE);
    checks++; if (q_int.size() != 2) begin errors++; $display("FAIL bin1_count got %0d want 2", q_int.size()); end
    for (int i = 0; i < q_int.size(); i++) begin
      checks++; if (q_int[i] != 2272 || q_hit[i] != 1 || q_bin[i] != 1) begin
        errors++; $display("FAIL bin1_result[%0d] got int %0d hit %0d bin %0d want 2272 1 1", i, q_int[i], q_hit[i], q_bin[i]);
      end
    end
    checks++; if (bin_hits[31:16] !== 16'd2 || bin_ticks[63:32] !== 32'd4544) begin
      errors++; $display("FAIL bin1_acc got hits %0d ticks %0d want 2 4544", bin_hits[31:16], bin_ticks[63:32]);
    end
    bin_high[31:16] = 16'd3000;
    rearm(); flush_q();
    square(2600, 3); settle(SETTLE);
    checks++; if (q_int.size() != 2) begin errors++; $display("FAIL overlap_count got %0d want 2", q_int.size()); end
    for (int i = 0; i < q_int.size(); i++) begin
      checks++; if (q_int[i] != 2600 || q_hit[i] != 1 || q_bin[i] != 0) begin
        errors++; $display("FAIL overlap_result[%0d] got int %0d hit %0d bin %0d want 2600 1 0", i, q_int[i], q_hit[i], q_bin[i]);
      end
    end
    checks++; if (bin_hits[15:0] !== 16'd2 || bin_ticks[31:0] !== 32'd5200 || bin_hits[31:16] !== 16'd2) begin
      errors++; $display("FAIL overlap_acc got hits0 %0d ticks0 %0d hits1 %0d want 2 5200 2",
                         bin_hits[15:0], bin_ticks[31:0], bin_hits[31:16]);
    end
    bin_high[31:16] = 16'd2499;
  endtask

  task automatic test_miss_timeout();
    int waited;
    rearm(); pulse_acc_clear(); flush_q();
    square(1000, 4); settle(SETTLE);
    checks++; if (q_int.size() != 3) begin errors++; $display("FAIL miss_count_results got %0d want 3", q_int.size()); end
    for (int i = 0; i < q_int.size(); i++) begin
      checks++; if (q_int[i] != 1000 || q_hit[i] != 0 || q_bin[i] != 0) begin
        errors++; $display("FAIL miss_result[%0d] got int %0d hit %0d bin %0d want 1000 0 0", i, q_int[i], q_hit[i], q_bin[i]);
      end
    end
    checks++; if (miss_count !== 16'd3 || bin_hits !== 32'd0) begin
      errors++; $display("FAIL miss_counters got miss %0d hits %0h want 3 0", miss_count, bin_hits);
    end
    qs_int.delete(); qs_hit.delete();
    waited = 0;
    while (qs_int.size() == 0 && waited < 5000) begin
      @(negedge clock);
      waited++;
    end
    checks++;
    if (qs_int.size() == 0) begin
      errors++; $display("FAIL timeout_strobe got none in %0d cycles want 1", waited);
    end else if (qs_int[0] != 4095 || qs_hit[0] != 0) begin
      errors++; $display("FAIL timeout_strobe got int %0d hit %0d want 4095 0", qs_int[0], qs_hit[0]);
    end
    checks++; if (miss_s !== 16'd4) begin errors++; $display("FAIL timeout_miss got %0d want 4", miss_s); end
    toggle(); settle(SETTLE);
    checks++; if (qs_int.size() != 1 || miss_s !== 16'd4) begin
      errors++; $display("FAIL rearm_edge got results %0d miss %0d want 1 4", qs_int.size(), miss_s);
    end
  endtask

  task automatic test_enable_drop();
    rearm(); pulse_acc_clear();
    square(2777, 3); settle(SETTLE);
    flush_q();
    settle(1000);
    enable = 1'b0;
    settle(3);
    enable = 1'b1;
    settle(1000);
    toggle(); settle(SETTLE);
    checks++; if (q_int.size() != 0 || bin_hits[15:0] !== 16'd2 || miss_count !== 16'd0) begin
      errors++; $display("FAIL enable_drop got results %0d hits %0d miss %0d want 0 2 0", q_int.size(), bin_hits[15:0], miss_count);
    end
    settle(2777 - SETTLE);
    toggle(); settle(SETTLE);
    checks++; if (q_int.size() != 1 || bin_hits[15:0] !== 16'd3 || bin_ticks[31:0] !== 32'd8331) begin
      errors++; $display("FAIL enable_resume got results %0d hits %0d ticks %0d want 1 3 8331",
                         q_int.size(), bin_hits[15:0], bin_ticks[31:0]);
    end
  endtask

  task automatic test_saturation_and_clears();
    rearm(); pulse_acc_clear();
    square(2777, 3); settle(SETTLE);
    checks++; if (ticks_s[11:0] !== 12'hFFF || hits_s[15:0] !== 16'd2) begin
      errors++; $display("FAIL saturate got ticks %0h hits %0d want fff 2", ticks_s[11:0], hits_s[15:0]);
    end
    checks++; if (bin_ticks[31:0] !== 32'd5554) begin errors++; $display("FAIL wide_ticks got %0d want 5554", bin_ticks[31:0]); end
    settle(2777 - SETTLE);
    toggle();
    settle(LAT);
    acc_clear = 1'b1;
    @(negedge clock);
    acc_clear = 1'b0;
    checks++; if (result_valid !== 1'b1) begin errors++; $display("FAIL coincide_strobe got %0b want 1", result_valid); end
    checks++; if (bin_ticks !== 64'd0 || bin_hits !== 32'd0 || miss_count !== 16'd0 || hits_s !== 32'd0) begin
      errors++; $display("FAIL coincide_clear got ticks %0h hits %0h miss %0d want 0 0 0", bin_ticks, bin_hits, miss_count);
    end
    settle(2777 - LAT - 1);
    toggle(); settle(SETTLE);
    checks++; if (bin_hits[15:0] !== 16'd1) begin errors++; $display("FAIL post_clear_hit got %0d want 1", bin_hits[15:0]); end
    settle(1000);
    #2 clear = 1'b0;
    #1;
    checks++; if (bin_ticks !== 64'd0 || bin_hits !== 32'd0 || miss_count !== 16'd0 ||
                  result_interval !== 16'd0 || ticks_s !== 24'd0) begin
      errors++; $display("FAIL async_clear got ticks %0h hits %0h miss %0d interval %0d want all 0",
                         bin_ticks, bin_hits, miss_count, result_interval);
    end
    @(negedge clock);
    clear = 1'b1;
    settle(2);
  endtask

  task automatic test_glitch();
    rearm(); pulse_acc_clear(); flush_q();
    toggle(); settle(1000);
    toggle(); settle(2);
    toggle(); settle(1775);
    toggle(); settle(SETTLE);
`ifdef MFA_GLITCH_FILTER_EN
    checks++; if (q_int.size() != 1 || bin_hits[15:0] !== 16'd1 || miss_count !== 16'd0) begin
      errors++; $display("FAIL glitch_filtered got results %0d hits %0d miss %0d want 1 1 0", q_int.size(), bin_hits[15:0], miss_count);
    end
    checks++; if (q_int.size() > 0 && q_int[0] != 2777) begin errors++; $display("FAIL glitch_interval got %0d want 2777", q_int[0]); end
`else
    checks++; if (q_int.size() != 3 || bin_hits[15:0] !== 16'd0 || miss_count !== 16'd3) begin
      errors++; $display("FAIL glitch_raw got results %0d hits %0d miss %0d want 3 0 3", q_int.size(), bin_hits[15:0], miss_count);
    end
    checks++; if (q_int.size() == 3 && (q_int[0] != 1000 || q_int[1] != 2 || q_int[2] != 1775)) begin
      errors++; $display("FAIL glitch_intervals got %0d %0d %0d want 1000 2 1775", q_int[0], q_int[1], q_int[2]);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_tone_bin0();
    test_bin1_and_overlap();
    test_miss_timeout();
    test_enable_drop();
    test_saturation_and_clears();
    test_glitch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
